my_ifft_n4: RTL

Streaming 4-point radix-4 inverse DFT. It consumes frequency-domain frames produced by the team's 4-point forward FFT (same first-word flag, same DATA_WIDTH+1 sample width) and emits the time-domain frame, scaled by 1/4 and saturated back to DATA_WIDTH. The block sits on the receive/synthesis side of the FFT chain, and an FFT→IFFT round trip of integer data is bit-exact.

---
 rtl/my_ifft_n4.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/my_ifft_n4.sv
// my_ifft_n4 -- streaming 4-point radix-4 inverse DFT.
//
// Accepts 4-word frequency-domain frames (X0..X3, DATA_WIDTH+1 bit complex
// samples, X0 marked by data_in_flag_i, no gaps) and emits the matching
// time-domain frame x0..x3, scaled by 1/4 (floor) and saturated to
// DATA_WIDTH bits. Flag-to-flag latency is 5 cycles, one frame per 4 cycles.
//
// Ports:
//   sys_clk_i        - system clock, rising edge
//   sys_rst_n_i      - synchronous active-low reset
//   data_in_flag_i   - high on X0 of an input frame
//   xk_real_i/imag_i - input sample Xk, signed DATA_WIDTH+1
//   data_out_flag_o  - high on x0 of an output frame
//   data_out_valid_o - high on all four output words
//   xn_real_o/imag_o - output sample xn, signed DATA_WIDTH (0 when not valid)

module my_ifft_n4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_n_i,
  input  logic                         data_in_flag_i,
  input  logic signed [DATA_WIDTH:0]   xk_real_i,
  input  logic signed [DATA_WIDTH:0]   xk_imag_i,
  output logic                         data_out_flag_o,
  output logic                         data_out_valid_o,
  output logic signed [DATA_WIDTH-1:0] xn_real_o,
  output logic signed [DATA_WIDTH-1:0] xn_imag_o
);

  localparam int IW  = DATA_WIDTH + 1;  // input sample width
  localparam int S1W = DATA_WIDTH + 2;  // first butterfly stage
  localparam int S2W = DATA_WIDTH + 3;  // second butterfly stage

  // ---------------------------------------------------------------------
  // Input framing FSM
  // ---------------------------------------------------------------------
  typedef enum logic {IDLE, COLLECT} state_t;

  state_t     state, state_next;
  logic [1:0] in_cnt, in_cnt_next;
  logic       cap_we;
  logic [1:0] cap_idx;
  logic       frame_done;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state  <= IDLE;
      in_cnt <= 2'd0;
    end else begin
      state  <= state_next;
      in_cnt <= in_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_cnt_next = in_cnt;
    cap_we      = 1'b0;
    cap_idx     = 2'd0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (data_in_flag_i) begin
          cap_we      = 1'b1;
          cap_idx     = 2'd0;
          in_cnt_next = 2'd1;
          state_next  = COLLECT;
        end
      end
      COLLECT: begin
        if (data_in_flag_i) begin
          // Restart: the current word becomes X0 of a new frame.
          cap_we      = 1'b1;
          cap_idx     = 2'd0;
          in_cnt_next = 2'd1;
        end else if (in_cnt == 2'd3) begin
          // X3 is not stored; it feeds stage 1 straight from the input.
          frame_done  = 1'b1;
          in_cnt_next = 2'd0;
          state_next  = IDLE;
        end else begin
          cap_we      = 1'b1;
          cap_idx     = in_cnt;
          in_cnt_next = in_cnt + 2'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        in_cnt_next = 2'd0;
      end
    endcase
  end

  // Capture registers for X0..X2
  logic signed [IW-1:0] cap_re [0:2];
  logic signed [IW-1:0] cap_im [0:2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cap
      always_ff @(posedge sys_clk_i) begin
        if (cap_we && (cap_idx == 2'(gi))) begin
          cap_re[gi] <= xk_real_i;
          cap_im[gi] <= xk_imag_i;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stage 1: a = X0+X2, b = X0-X2, c = X1+X3, d = X1-X3
  // ---------------------------------------------------------------------
  logic signed [S1W-1:0] x0_re, x0_im, x1_re, x1_im;
  logic signed [S1W-1:0] x2_re, x2_im, x3_re, x3_im;

  assign x0_re = S1W'(cap_re[0]);
  assign x0_im = S1W'(cap_im[0]);
  assign x1_re = S1W'(cap_re[1]);
  assign x1_im = S1W'(cap_im[1]);
  assign x2_re = S1W'(cap_re[2]);
  assign x2_im = S1W'(cap_im[2]);
  assign x3_re = S1W'(xk_real_i);
  assign x3_im = S1W'(xk_imag_i);

  logic signed [S1W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic                  s1_valid;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= frame_done;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (frame_done) begin
      a_re <= x0_re + x2_re;
      a_im <= x0_im + x2_im;
      b_re <= x0_re - x2_re;
      b_im <= x0_im - x2_im;
      c_re <= x1_re + x3_re;
      c_im <= x1_im + x3_im;
      d_re <= x1_re - x3_re;
      d_im <= x1_im - x3_im;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: s0 = a+c, s2 = a-c, s1 = b + j*d, s3 = b - j*d
  // ---------------------------------------------------------------------
  logic signed [S2W-1:0] s_re [0:3];
  logic signed [S2W-1:0] s_im [0:3];

  assign s_re[0] = S2W'(a_re) + S2W'(c_re);
  assign s_im[0] = S2W'(a_im) + S2W'(c_im);
  assign s_re[2] = S2W'(a_re) - S2W'(c_re);
  assign s_im[2] = S2W'(a_im) - S2W'(c_im);
  assign s_re[1] = S2W'(b_re) - S2W'(d_im);
  assign s_im[1] = S2W'(b_im) + S2W'(d_re);
  assign s_re[3] = S2W'(b_re) + S2W'(d_im);
  assign s_im[3] = S2W'(b_im) - S2W'(d_re);

  // Divide by 4 with floor rounding, then clamp to DATA_WIDTH. The value
  // fits when every bit from the DATA_WIDTH-1 position upward equals the sign.
  localparam int TOPW = S2W - DATA_WIDTH + 1;

  function automatic logic signed [DATA_WIDTH-1:0] scale_sat(
    input logic signed [S2W-1:0] s
  );
    logic signed [S2W-1:0] sh;
    logic [TOPW-1:0]       top;
    sh  = s >>> 2;
    top = sh[S2W-1:DATA_WIDTH-1];
    if ((top == {TOPW{1'b0}}) || (top == {TOPW{1'b1}})) begin
      return sh[DATA_WIDTH-1:0];
    end else if (sh[S2W-1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

  logic signed [DATA_WIDTH-1:0] sat_re [0:3];
  logic signed [DATA_WIDTH-1:0] sat_im [0:3];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sat
      assign sat_re[gi] = scale_sat(s_re[gi]);
      assign sat_im[gi] = scale_sat(s_im[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output buffer: x0 goes straight to the output registers on load, x1..x3
  // wait in a 3-entry shift buffer. A new load (back-to-back frame) lands in
  // the same cycle the previous frame's x3 is on the output, so it simply
  // takes priority over the shift.
  // ---------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] obuf_re [0:2];
  logic signed [DATA_WIDTH-1:0] obuf_im [0:2];
  logic [1:0]                   out_left;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      out_left         <= 2'd0;
      data_out_flag_o  <= 1'b0;
      data_out_valid_o <= 1'b0;
      xn_real_o        <= '0;
      xn_imag_o        <= '0;
    end else if (s1_valid) begin
      out_left         <= 2'd3;
      data_out_flag_o  <= 1'b1;
      data_out_valid_o <= 1'b1;
      xn_real_o        <= sat_re[0];
      xn_imag_o        <= sat_im[0];
    end else if (out_left != 2'd0) begin
      out_left         <= out_left - 2'd1;
      data_out_flag_o  <= 1'b0;
      data_out_valid_o <= 1'b1;
      xn_real_o        <= obuf_re[0];
      xn_imag_o        <= obuf_im[0];
    end else begin
      data_out_flag_o  <= 1'b0;
      data_out_valid_o <= 1'b0;
      xn_real_o        <= '0;
      xn_imag_o        <= '0;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (s1_valid) begin
      for (int i = 0; i < 3; i++) begin
        obuf_re[i] <= sat_re[i+1];
        obuf_im[i] <= sat_im[i+1];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        obuf_re[i] <= obuf_re[i+1];
        obuf_im[i] <= obuf_im[i+1];
      end
    end
  end

endmodule
